demux_stream: RTL and testbench
===============================

Name: demux_stream

Overview:
- 1-to-3 demultiplexer for WIDTH-bit data; the return path for the 3:1 mux (A/B/C inputs, s1/s0 select).
- Accepts one beat per cycle on a valid/ready input and routes it by {s1,s0} to output channel A, B or C.
- Each output channel has a one-entry registered slot with its own valid/ready handshake.
- Beats with an unmapped select are discarded and counted.

Parameters:
- WIDTH, 4, data width of input and each output channel.
- CNT_W, 8, width of the saturating drop counter.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  reset; synchronous, active-low.
- in_data  input  WIDTH  input beat data.
- s1  input  1  select MSB.
- s0  input  1  select LSB.
- in_valid  input  1  input beat present.
- in_ready  output  1  block can accept the input beat this cycle.
- a_data  output  WIDTH  channel A data.
- a_valid  output  1  channel A slot full.
- a_ready  input  1  channel A consumer accepts.
- b_data, b_valid, b_ready: as for A, channel B.
- c_data, c_valid, c_ready: as for A, channel C.
- drop_cnt  output  CNT_W  count of discarded beats (select 11).

Behaviour:
- Select map: 00 -> A, 01 -> B, 10 -> C, 11 -> drop.
- s1/s0 are sampled only on an accepted beat (in_valid && in_ready).
- Reset (rst_n=0 at a clk edge): all *_valid=0, all *_data=0, drop_cnt=0. Applies mid-transfer; held slot contents are lost.
- in_ready is combinational, with no dependence on in_valid:
  - select 00/01/10: in_ready = !x_valid || x_ready for the selected slot x.
  - select 11: in_ready = 1.
- Slot x update, per cycle:
  - fill: accept && select==x.
  - drain: x_valid && x_ready.
  - fill only: x_valid<=1, x_data<=in_data.
  - drain only: x_valid<=0, x_data holds its last value.
  - fill and drain in the same cycle: x_valid stays 1, x_data<=in_data. This gives full throughput, one beat per cycle per channel.
  - neither: hold.
- x_data must stay stable while x_valid && !x_ready.
- Latency: a beat accepted at edge N is visible on x_data/x_valid after edge N, so one cycle.
- Unselected slots are unaffected by an accepted beat. Back-pressure on one channel does not block beats routed to another.
- Drop: an accepted beat with select 11 increments drop_cnt. drop_cnt saturates at 2^CNT_W-1 and never wraps.
- in_valid=0: no state change except drains.

Optional Feature:
- Macro DEMUX_BROADCAST_EN.
- Defined:
  - select 11 broadcasts the beat to A, B and C simultaneously.
  - in_ready for select 11 = all three slots can accept (each !x_valid || x_ready).
  - An accepted broadcast fills all three slots.
  - drop_cnt is tied to 0.
- Undefined: select 11 drops and counts as above.

Decomposition:
- Package demux_pkg holds:
  - localparams SEL_A=2'b00, SEL_B=2'b01, SEL_C=2'b10, SEL_DROP=2'b11.
  - default WIDTH and CNT_W.
- Sub-module demux_slot: a one-entry WIDTH-bit valid/ready holding register.
  - Ports: clk, rst_n, fill, fill_data, out_data, out_valid, out_ready, can_accept.
  - Instantiated three times.
- Top level: select decode, in_ready mux, drop counter.

Test Plan:
- Reset: rst_n=0 for 2 cycles with in_valid=1 -> all *_valid=0, *_data=0, drop_cnt=0. Mid-stream reset clears a full slot.
- Routing: all readies=1, in_data=1010/1111/0110 with sel=00/01/10 on consecutive cycles -> a_data=1010, b_data=1111, c_data=0110, each valid one cycle after accept, one beat per cycle.
- Back-pressure:
  - a_ready=0, send 1010 then 0011 to A -> a_data holds 1010, in_ready=0 for the second beat.
  - A beat to B on the next cycle is accepted (in_ready=1).
  - Raise a_ready -> 0011 is accepted in the same cycle 1010 drains.
- Simultaneous fill/drain: a_valid=1, a_ready=1, new beat 0101 to A -> a_valid stays 1, a_data=0101 next cycle.
- Drop and saturation:
  - Send 5 beats with sel=11 -> drop_cnt=5, no output valid asserts.
  - With CNT_W=3, send 10 -> drop_cnt=7.
- DEMUX_BROADCAST_EN:
  - sel=11, in_data=1100, c_ready=0 with C full -> in_ready=0.
  - After C drains -> all three slots show 1100; drop_cnt=0.

Source files
------------

// File: rtl/demux_pkg.sv
// Shared select encodings and default sizes for the stream demultiplexer.
package demux_pkg;

  localparam logic [1:0] SEL_A    = 2'b00;
  localparam logic [1:0] SEL_B    = 2'b01;
  localparam logic [1:0] SEL_C    = 2'b10;
  localparam logic [1:0] SEL_DROP = 2'b11;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_CNT_W = 8;

endpackage

// File: rtl/demux_slot.sv
// One-entry valid/ready holding register for a single demux output channel.
module demux_slot #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             fill,
  input  logic [WIDTH-1:0] fill_data,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             can_accept
);

  // A full slot can still take a beat in the same cycle it drains.
  assign can_accept = !out_valid || out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (fill) begin
      out_valid <= 1'b1;
      out_data  <= fill_data;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/demux_stream.sv
// 1-to-3 stream demux: routes beats by {s1,s0} to slots A/B/C; select 11 drops and counts.
// Build option DEMUX_BROADCAST_EN turns select 11 into a broadcast to all three slots.
module demux_stream
  import demux_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             s1,
  input  logic             s0,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] a_data,
  output logic             a_valid,
  input  logic             a_ready,
  output logic [WIDTH-1:0] b_data,
  output logic             b_valid,
  input  logic             b_ready,
  output logic [WIDTH-1:0] c_data,
  output logic             c_valid,
  input  logic             c_ready,
  output logic [CNT_W-1:0] drop_cnt
);

  logic [1:0] sel;
  logic       a_can, b_can, c_can;
  logic       accept;
  logic       fill_a, fill_b, fill_c;

  assign sel = {s1, s0};

  // in_ready depends only on select and slot state, never on in_valid.
  always_comb begin
    in_ready = 1'b1;
    case (sel)
      SEL_A:   in_ready = a_can;
      SEL_B:   in_ready = b_can;
      SEL_C:   in_ready = c_can;
      default: begin
`ifdef DEMUX_BROADCAST_EN
        in_ready = a_can && b_can && c_can;
`else
        in_ready = 1'b1;
`endif
      end
    endcase
  end

  assign accept = in_valid && in_ready;

`ifdef DEMUX_BROADCAST_EN
  logic bcast;
  assign bcast  = accept && (sel == SEL_DROP);
  assign fill_a = (accept && (sel == SEL_A)) || bcast;
  assign fill_b = (accept && (sel == SEL_B)) || bcast;
  assign fill_c = (accept && (sel == SEL_C)) || bcast;
  assign drop_cnt = '0;
`else
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  logic [CNT_W-1:0] drop_q;

  assign fill_a = accept && (sel == SEL_A);
  assign fill_b = accept && (sel == SEL_B);
  assign fill_c = accept && (sel == SEL_C);

  // Saturating: sticks at all-ones rather than wrapping.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      drop_q <= '0;
    end else if (accept && (sel == SEL_DROP) && (drop_q != CNT_MAX)) begin
      drop_q <= drop_q + CNT_W'(1);
    end
  end

  assign drop_cnt = drop_q;
`endif

  demux_slot #(.WIDTH(WIDTH)) u_slot_a (
    .clk        (clk),
    .rst_n      (rst_n),
    .fill       (fill_a),
    .fill_data  (in_data),
    .out_data   (a_data),
    .out_valid  (a_valid),
    .out_ready  (a_ready),
    .can_accept (a_can)
  );

  demux_slot #(.WIDTH(WIDTH)) u_slot_b (
    .clk        (clk),
    .rst_n      (rst_n),
    .fill       (fill_b),
    .fill_data  (in_data),
    .out_data   (b_data),
    .out_valid  (b_valid),
    .out_ready  (b_ready),
    .can_accept (b_can)
  );

  demux_slot #(.WIDTH(WIDTH)) u_slot_c (
    .clk        (clk),
    .rst_n      (rst_n),
    .fill       (fill_c),
    .fill_data  (in_data),
    .out_data   (c_data),
    .out_valid  (c_valid),
    .out_ready  (c_ready),
    .can_accept (c_can)
  );

endmodule

// File: tb/tb_demux_stream.sv
// Directed bench for demux_stream; a second CNT_W=3 instance shares the inputs to exercise saturation.
module tb_demux_stream;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] in_data;
  logic       s1, s0, in_valid;
  logic       a_ready, b_ready, c_ready;

  logic       in_ready, a_valid, b_valid, c_valid;
  logic [3:0] a_data, b_data, c_data;
  logic [7:0] drop_cnt;

  logic       sm_in_ready, sm_a_valid, sm_b_valid, sm_c_valid;
  logic [3:0] sm_a_data, sm_b_data, sm_c_data;
  logic [2:0] sm_drop_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  demux_stream #(.WIDTH(4), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .s1(s1), .s0(s0),
    .in_valid(in_valid), .in_ready(in_ready),
    .a_data(a_data), .a_valid(a_valid), .a_ready(a_ready),
    .b_data(b_data), .b_valid(b_valid), .b_ready(b_ready),
    .c_data(c_data), .c_valid(c_valid), .c_ready(c_ready),
    .drop_cnt(drop_cnt)
  );

  demux_stream #(.WIDTH(4), .CNT_W(3)) dut_sm (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .s1(s1), .s0(s0),
    .in_valid(in_valid), .in_ready(sm_in_ready),
    .a_data(sm_a_data), .a_valid(sm_a_valid), .a_ready(a_ready),
    .b_data(sm_b_data), .b_valid(sm_b_valid), .b_ready(b_ready),
    .c_data(sm_c_data), .c_valid(sm_c_valid), .c_ready(c_ready),
    .drop_cnt(sm_drop_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Advance one edge; outputs are sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] sel, input logic [3:0] d);
    in_valid = v;
    {s1, s0} = sel;
    in_data  = d;
    #1;
  endtask

  task automatic expect_valids(input string tag, input logic [2:0] abc);
    check({tag, "_valids"}, 32'({a_valid, b_valid, c_valid}), 32'(abc));
  endtask

  initial begin
    rst_n = 1'b0;
    a_ready = 1'b1; b_ready = 1'b1; c_ready = 1'b1;
    drive(1'b1, 2'b00, 4'b1010);

    // Reset held two edges with a beat presented
    tick(); tick();
    expect_valids("rst", 3'b000);
    check("rst_a_data", 32'(a_data), 32'h0);
    check("rst_b_data", 32'(b_data), 32'h0);
    check("rst_c_data", 32'(c_data), 32'h0);
    check("rst_drop", 32'(drop_cnt), 32'h0);
    check("rst_sm_drop", 32'(sm_drop_cnt), 32'h0);

    rst_n = 1'b1;
    drive(1'b0, 2'b00, 4'b0000);
    tick();

    // Routing, one beat per cycle, all readies high
    drive(1'b1, 2'b00, 4'b1010);
    check("rt_rdy_a", 32'(in_ready), 32'h1);
    tick();
    expect_valids("rt_a", 3'b100);
    check("rt_a_data", 32'(a_data), 32'hA);
    drive(1'b1, 2'b01, 4'b1111);
    check("rt_rdy_b", 32'(in_ready), 32'h1);
    tick();
    expect_valids("rt_b", 3'b010);
    check("rt_b_data", 32'(b_data), 32'hF);
    check("rt_a_hold", 32'(a_data), 32'hA);
    drive(1'b1, 2'b10, 4'b0110);
    tick();
    expect_valids("rt_c", 3'b001);
    check("rt_c_data", 32'(c_data), 32'h6);
    drive(1'b0, 2'b00, 4'b0000);
    tick();
    expect_valids("rt_idle", 3'b000);

    // Back-pressure on A does not block B
    a_ready = 1'b0;
    drive(1'b1, 2'b00, 4'b1010);
    tick();
    expect_valids("bp_fill", 3'b100);
    drive(1'b1, 2'b00, 4'b0011);
    check("bp_rdy_blocked", 32'(in_ready), 32'h0);
    tick();
    check("bp_a_hold", 32'(a_data), 32'hA);
    check("bp_a_valid", 32'(a_valid), 32'h1);
    drive(1'b1, 2'b01, 4'b1001);
    check("bp_rdy_b", 32'(in_ready), 32'h1);
    tick();
    check("bp_b_data", 32'(b_data), 32'h9);
    expect_valids("bp_b", 3'b110);
    check("bp_a_still", 32'(a_data), 32'hA);
    a_ready = 1'b1;
    drive(1'b1, 2'b00, 4'b0011);
    check("bp_rdy_release", 32'(in_ready), 32'h1);
    tick();
    check("bp_a_new", 32'(a_data), 32'h3);
    expect_valids("bp_swap", 3'b100);

    // Simultaneous fill and drain on A
    drive(1'b1, 2'b00, 4'b0101);
    check("fd_rdy", 32'(in_ready), 32'h1);
    tick();
    check("fd_a_valid", 32'(a_valid), 32'h1);
    check("fd_a_data", 32'(a_data), 32'h5);
    drive(1'b0, 2'b00, 4'b0000);
    tick();
    expect_valids("fd_drain", 3'b000);
    check("fd_data_kept", 32'(a_data), 32'h5);

`ifdef DEMUX_BROADCAST_EN
    // Broadcast blocked by a stalled full C, then released
    c_ready = 1'b0;
    drive(1'b1, 2'b10, 4'b0010);
    tick();
    drive(1'b1, 2'b11, 4'b1100);
    check("bc_rdy_blocked", 32'(in_ready), 32'h0);
    tick();
    expect_valids("bc_blocked", 3'b001);
    check("bc_c_hold", 32'(c_data), 32'h2);
    c_ready = 1'b1;
    #1;
    check("bc_rdy_open", 32'(in_ready), 32'h1);
    tick();
    expect_valids("bc_all", 3'b111);
    check("bc_a_data", 32'(a_data), 32'hC);
    check("bc_b_data", 32'(b_data), 32'hC);
    check("bc_c_data", 32'(c_data), 32'hC);
    check("bc_drop", 32'(drop_cnt), 32'h0);
    check("bc_sm_drop", 32'(sm_drop_cnt), 32'h0);
    drive(1'b0, 2'b00, 4'b0000);
    tick();
`else
    // Drops: five beats, then five more to saturate the 3-bit counter
    drive(1'b1, 2'b11, 4'b0111);
    check("dr_rdy", 32'(in_ready), 32'h1);
    for (int i = 0; i < 5; i++) tick();
    expect_valids("dr_none", 3'b000);
    check("dr_cnt5", 32'(drop_cnt), 32'd5);
    check("dr_sm_cnt5", 32'(sm_drop_cnt), 32'd5);
    for (int i = 0; i < 5; i++) tick();
    check("dr_cnt10", 32'(drop_cnt), 32'd10);
    check("dr_sm_sat", 32'(sm_drop_cnt), 32'd7);
    drive(1'b0, 2'b11, 4'b0111);
    tick();
    check("dr_idle_hold", 32'(drop_cnt), 32'd10);
    expect_valids("dr_none2", 3'b000);
`endif

    // Mid-stream reset clears a stalled full slot
    b_ready = 1'b0;
    drive(1'b1, 2'b01, 4'b1110);
    tick();
    check("mr_b_full", 32'(b_valid), 32'h1);
    drive(1'b0, 2'b00, 4'b0000);
    rst_n = 1'b0;
    tick();
    expect_valids("mr", 3'b000);
    check("mr_b_data", 32'(b_data), 32'h0);
    check("mr_a_data", 32'(a_data), 32'h0);
    check("mr_drop", 32'(drop_cnt), 32'h0);
    check("mr_sm_drop", 32'(sm_drop_cnt), 32'h0);
    rst_n = 1'b1;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
